muldiv_sequencer: RTL and testbench

Multicycle multiply/divide sequencer for the CPU's Hi/Lo unit. The control unit drives the operands from registers A and B. The block accepts one MULT/MULTU/DIV/DIVU command at a time and runs it through a single shared shift/add-subtract magnitude engine for WIDTH iterations. It then applies sign correction, writes Hi/Lo and pulses `done`, so the control unit holds its wait state until `done` is seen.

---
 rtl/muldiv_sequencer_pkg.sv | 20 ++
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 129 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and defaults for the Hi/Lo multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Command/result bundle between the control unit and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shared magnitude engine: shift-add multiply or restoring divide.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 isDiv,
  input  logic [2*WIDTH-1:0]   accIn,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accOut
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] diff;
  logic           diffNeg;

  // Compute both step flavours and select by command type
  always_comb begin
    sum      = {1'b0, accIn[2*WIDTH-1:WIDTH]};
    if (accIn[0]) begin
      sum = sum + {1'b0, operand};
    end
    remShift = accIn[2*WIDTH-1:WIDTH-1];
    diff     = remShift - {1'b0, operand};
    diffNeg  = diff[WIDTH];
    if (isDiv) begin
      accOut = {(diffNeg ? remShift[WIDTH-1:0] : diff[WIDTH-1:0]),
                accIn[WIDTH-2:0], ~diffNeg};
    end else begin
      accOut = {sum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer driving the CPU Hi/Lo registers.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] negW(input logic en, input logic [WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic en, input logic [2*WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  muldiv_state_t state, nextState;
  muldiv_op_t    opReg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   stepAcc;
  logic [WIDTH-1:0]     operandReg;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic                 prodNeg, quoNeg, remNeg, dzFlag;

  logic                 accept, isDivIn, signedIn, divZeroIn;
  logic [WIDTH-1:0]     aMag, bMag;
  logic                 signedOp;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quo, rem, fixHi, fixLo;

  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign isDivIn   = bus.op[1];
  assign signedIn  = ~bus.op[0];
  assign divZeroIn = isDivIn && (bus.b == '0);
  assign aMag      = signedIn ? absVal(bus.a) : bus.a;
  assign bMag      = signedIn ? absVal(bus.b) : bus.b;

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv   (opReg[1]),
    .accIn   (acc),
    .operand (operandReg),
    .accOut  (stepAcc)
  );

  // Sign correction of the magnitude result, consumed on the FIX->DONE edge
  always_comb begin
    signedOp = (opReg == MULT) || (opReg == DIV);
    product  = neg2W(signedOp && prodNeg, acc);
    quo      = negW(signedOp && quoNeg, acc[WIDTH-1:0]);
    rem      = negW(signedOp && remNeg, acc[2*WIDTH-1:WIDTH]);
    fixHi    = opReg[1] ? rem : product[2*WIDTH-1:WIDTH];
    fixLo    = opReg[1] ? quo : product[WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state: accept in IDLE/DONE, WIDTH RUN steps, one FIX, one DONE
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          nextState = divZeroIn ? DONE : RUN;
        end else begin
          nextState = IDLE;
        end
      end
      RUN:     nextState = (cnt == LAST_CNT) ? FIX : RUN;
      FIX:     nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, iteration, counter and Hi/Lo write-back
  always_ff @(posedge clock) begin
    if (reset) begin
      opReg      <= MULT;
      cnt        <= '0;
      acc        <= '0;
      operandReg <= '0;
      prodNeg    <= 1'b0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      dzFlag     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else if (accept) begin
      opReg      <= muldiv_op_t'(bus.op);
      cnt        <= '0;
      acc        <= {{WIDTH{1'b0}}, (isDivIn ? aMag : bMag)};
      operandReg <= isDivIn ? bMag : aMag;
      prodNeg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      quoNeg     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      remNeg     <= bus.a[WIDTH-1];
      dzFlag     <= divZeroIn;
    end else if (state == RUN) begin
      acc        <= stepAcc;
      cnt        <= cnt + 1'b1;
    end else if (state == FIX) begin
      hiReg      <= fixHi;
      loReg      <= fixLo;
    end
  end

  assign bus.busy     = (state == RUN) || (state == FIX);
  assign bus.done     = (state == DONE);
  assign bus.div_zero = (state == DONE) && dzFlag;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, div-by-zero, ignore/back-to-back, reset abort.
module tb_muldiv_sequencer;

  logic clock;
  logic reset;
  int   nChecks;
  int   nPass;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a command so it is sampled on the next rising edge (cycle 0), then drop start.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Count cycles after acceptance until done, bounded at 100 cycles.
  task automatic waitDone(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else nPass++;
    nChecks++; if (bus.div_zero !== 1'b0) $display("FAIL reset_divzero got %0b want 0", bus.div_zero); else nPass++;
    nChecks++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else nPass++;
    nChecks++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else nPass++;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int badBusy;
    int doneCyc;
    badBusy = 0;
    doneCyc = -1;
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c <= 33 && bus.busy !== 1'b1) badBusy++;
      if (bus.done === 1'b1 && doneCyc < 0) begin
        doneCyc = c;
        nChecks++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", bus.hi); else nPass++;
        nChecks++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo got %h want ffffffeb", bus.lo); else nPass++;
        nChecks++; if (bus.div_zero !== 1'b0) $display("FAIL mult_divzero got %0b want 0", bus.div_zero); else nPass++;
        nChecks++; if (bus.busy !== 1'b0) $display("FAIL mult_busy_done got %0b want 0", bus.busy); else nPass++;
      end
    end
    nChecks++; if (badBusy != 0) $display("FAIL mult_busy_run got %0d bad cycles want 0", badBusy); else nPass++;
    nChecks++; if (doneCyc != 34) $display("FAIL mult_latency got %0d want 34", doneCyc); else nPass++;
  endtask

  task automatic test_multu();
    int cyc; bit got;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cyc, got);
    nChecks++; if (!got || cyc != 34) $display("FAIL multu_latency got %0d want 34", cyc); else nPass++;
    nChecks++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else nPass++;
    nChecks++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else nPass++;
  endtask

  task automatic test_div();
    int cyc; bit got;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    waitDone(cyc, got);
    nChecks++; if (!got || cyc != 34) $display("FAIL div_latency got %0d want 34", cyc); else nPass++;
    nChecks++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", bus.lo); else nPass++;
    nChecks++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", bus.hi); else nPass++;
  endtask

  task automatic test_div_overflow();
    int cyc; bit got;
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(cyc, got);
    nChecks++; if (!got) $display("FAIL divovf_done got timeout want done"); else nPass++;
    nChecks++; if (bus.lo !== 32'h8000_0000) $display("FAIL divovf_lo got %h want 80000000", bus.lo); else nPass++;
    nChecks++; if (bus.hi !== 32'h0) $display("FAIL divovf_hi got %h want 00000000", bus.hi); else nPass++;
  endtask

  task automatic test_divu();
    int cyc; bit got;
    issue(2'b11, 32'd100, 32'd7);
    waitDone(cyc, got);
    nChecks++; if (!got || cyc != 34) $display("FAIL divu_latency got %0d want 34", cyc); else nPass++;
    nChecks++; if (bus.lo !== 32'd14) $display("FAIL divu_lo got %h want 0000000e", bus.lo); else nPass++;
    nChecks++; if (bus.hi !== 32'd2) $display("FAIL divu_hi got %h want 00000002", bus.hi); else nPass++;
  endtask

  // Hi/Lo preloaded by the DIVU 100/7 that precedes this test.
  task automatic test_div_zero();
    issue(2'b10, 32'd55, 32'd0);
    @(negedge clock);
    nChecks++; if (bus.done !== 1'b1) $display("FAIL divz_done got %0b want 1", bus.done); else nPass++;
    nChecks++; if (bus.div_zero !== 1'b1) $display("FAIL divz_flag got %0b want 1", bus.div_zero); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL divz_busy got %0b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.hi !== 32'd2) $display("FAIL divz_hi got %h want 00000002", bus.hi); else nPass++;
    nChecks++; if (bus.lo !== 32'd14) $display("FAIL divz_lo got %h want 0000000e", bus.lo); else nPass++;
    @(negedge clock);
    nChecks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0)
      $display("FAIL divz_pulse got done=%0b dz=%0b want 0/0", bus.done, bus.div_zero); else nPass++;
  endtask

  task automatic test_start_ignored();
    int nDone;
    int doneCyc;
    nDone   = 0;
    doneCyc = -1;
    issue(2'b01, 32'd5, 32'd6);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        nDone++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (c == 34) begin
        nChecks++; if (bus.lo !== 32'd30 || bus.hi !== 32'd0)
          $display("FAIL ignore_result got %h_%h want 00000000_0000001e", bus.hi, bus.lo); else nPass++;
      end
      if (c == 5 || c == 20) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    nChecks++; if (nDone != 1) $display("FAIL ignore_count got %0d dones want 1", nDone); else nPass++;
    nChecks++; if (doneCyc != 34) $display("FAIL ignore_latency got %0d want 34", doneCyc); else nPass++;
  endtask

  task automatic test_back_to_back();
    int firstCyc;
    int secondCyc;
    firstCyc  = -1;
    secondCyc = -1;
    issue(2'b01, 32'd3, 32'd4);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (c == 36) begin
        bus.a  = 32'd0;
        bus.b  = 32'd0;
        bus.op = 2'b00;
      end
      if (c == 35) begin
        nChecks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %0b want 1", bus.busy); else nPass++;
      end
      if (bus.done === 1'b1) begin
        if (firstCyc < 0) begin
          firstCyc = c;
          nChecks++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0)
            $display("FAIL b2b_first got %h_%h want 00000000_0000000c", bus.hi, bus.lo); else nPass++;
          bus.start = 1'b1;
          bus.op    = 2'b11;
          bus.a     = 32'd100;
          bus.b     = 32'd7;
        end else if (secondCyc < 0) begin
          secondCyc = c;
          nChecks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2)
            $display("FAIL b2b_second got %h_%h want 00000002_0000000e", bus.hi, bus.lo); else nPass++;
        end
      end
    end
    nChecks++; if (firstCyc != 34) $display("FAIL b2b_first_latency got %0d want 34", firstCyc); else nPass++;
    nChecks++; if (secondCyc != 68) $display("FAIL b2b_second_latency got %0d want 68", secondCyc); else nPass++;
  endtask

  task automatic test_reset_mid();
    int nDone;
    nDone = 0;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1) nDone++;
      if (c == 10) reset = 1'b1;
      if (c == 11) begin
        nChecks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", bus.busy); else nPass++;
        nChecks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
          $display("FAIL rstmid_hilo got %h_%h want 0_0", bus.hi, bus.lo); else nPass++;
        reset = 1'b0;
      end
    end
    nChecks++; if (nDone != 0) $display("FAIL rstmid_nodone got %0d dones want 0", nDone); else nPass++;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_divu();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
